// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int          ITER_COUNT = 32;
   localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

endpackage

// File: rtl/muldiv_hilo_div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step (
   input  logic [31:0] rem_in,
   input  logic        dividend_bit,
   input  logic [31:0] divisor,
   output logic [31:0] rem_out,
   output logic        quot_bit
);

   logic [32:0] shifted;
   logic [32:0] diff;

   // A borrow out of bit 32 means the divisor did not fit, so restore.
   assign shifted  = {rem_in, dividend_bit};
   assign diff     = shifted - {1'b0, divisor};
   assign quot_bit = ~diff[32];
   assign rem_out  = quot_bit ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Optional single-cycle multiply when MULDIV_FAST_MUL_EN is defined.
module muldiv_hilo
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_e      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] opnd_q, opnd_d;
   logic [63:0] acc_q, acc_d;
   logic        neg_q, neg_d;
   logic        neg_rem_q, neg_rem_d;
   logic        div0_q, div0_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        a_neg, b_neg;
   logic [31:0] abs_a, abs_b;
   logic [32:0] mul_sum;
   logic [63:0] mul_next, div_next, iter_next, prod;
   logic [31:0] rem_out, quot, rem;
   logic        quot_bit;
   logic        fast_sel;
   logic [63:0] fast_prod;

   assign a_neg = ~op[0] & a[31];
   assign b_neg = ~op[0] & b[31];
   assign abs_a = a_neg ? -a : a;
   assign abs_b = b_neg ? -b : b;

   // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide.
   assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
   assign mul_next = {mul_sum, acc_q[31:1]};

   div_restore_step u_step (
      .rem_in       (acc_q[63:32]),
      .dividend_bit (acc_q[31]),
      .divisor      (opnd_q),
      .rem_out      (rem_out),
      .quot_bit     (quot_bit)
   );

   assign div_next = {rem_out, acc_q[30:0], quot_bit};

`ifdef MULDIV_FAST_MUL_EN
   assign fast_sel  = ~op_q[1];
   assign fast_prod = 64'(opnd_q) * 64'(acc_q[31:0]);
`else
   assign fast_sel  = 1'b0;
   assign fast_prod = 64'd0;
`endif

   assign iter_next = fast_sel ? fast_prod : (op_q[1] ? div_next : mul_next);
   assign prod      = neg_q ? -iter_next : iter_next;
   assign quot      = iter_next[31:0];
   assign rem       = iter_next[63:32];

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      op_d      = op_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d      = op;
               neg_d     = a_neg ^ b_neg;
               count_d   = 5'(ITER_COUNT - 1);
               state_d   = RUN;
               busy_d    = 1'b1;
               if (op[1]) begin
                  opnd_d    = abs_b;
                  acc_d     = {32'd0, abs_a};
                  neg_rem_d = a_neg;
                  div0_d    = (b == 32'd0);
               end else begin
                  opnd_d    = abs_a;
                  acc_d     = {32'd0, abs_b};
                  neg_rem_d = 1'b0;
                  div0_d    = 1'b0;
               end
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end
         RUN: begin
            acc_d   = iter_next;
            count_d = count_q - 5'd1;
            if (count_q == 5'd0 || fast_sel) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (op_q[1]) begin
                  lo_d = div0_q ? DIV0_QUOT : (neg_q ? -quot : quot);
                  hi_d = neg_rem_q ? -rem : rem;
               end else begin
                  hi_d = prod[63:32];
                  lo_d = prod[31:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         count_q   <= 5'd0;
         op_q      <= OP_MULT;
         opnd_q    <= 32'd0;
         acc_q     <= 64'd0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         op_q      <= op_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo against an arithmetic reference model.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_hilo;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checkCount = 0;
   int passCount  = 0;

   muldiv_hilo dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   // Returns {HI, LO} computed with plain 64-bit arithmetic.
   function automatic logic [63:0] refModel(input logic [1:0] opIn, input logic [31:0] aIn,
                                            input logic [31:0] bIn);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     res;
      sa = longint'($signed(aIn));
      sb = longint'($signed(bIn));
      ua = {32'd0, aIn};
      ub = {32'd0, bIn};
      res = 64'd0;
      case (opIn)
         OP_MULT:  res = sa * sb;
         OP_MULTU: res = ua * ub;
         OP_DIV: begin
            if (bIn == 32'd0) res = {aIn, 32'hFFFF_FFFF};
            else begin
               sq = sa / sb;
               sr = sa % sb;
               res = {sr[31:0], sq[31:0]};
            end
         end
         default: begin
            if (bIn == 32'd0) res = {aIn, 32'hFFFF_FFFF};
            else begin
               uq = ua / ub;
               ur = ua % ub;
               res = {ur[31:0], uq[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
   endtask

   // Called at a negedge; issues the op there and returns at the negedge of the done cycle.
   task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                                input bit disturb, input bit weWithStart);
      logic [63:0] expected;
      int          cycles;
      int          expLat;
      bit          busyDropped;
      expected = refModel(opIn, aIn, bIn);
      expLat = 32;
`ifdef MULDIV_FAST_MUL_EN
      if (!opIn[1]) expLat = 1;
`endif
      start = 1'b1;
      op = opIn;
      a = aIn;
      b = bIn;
      if (weWithStart) begin
         hi_we = 1'b1;
         lo_we = 1'b1;
         wdata = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      a = $urandom;
      b = $urandom;
      cycles = 0;
      busyDropped = 1'b0;
      while (!done && cycles < 40) begin
         if (!busy) busyDropped = 1'b1;
         if (disturb) begin
            start = 1'b1;
            op = 2'($urandom);
            hi_we = 1'b1;
            lo_we = 1'($urandom);
            wdata = 32'h1234;
         end
         cycles++;
         @(negedge clk);
      end
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      checkOutput("latency", 64'(cycles), 64'(expLat));
      checkOutput("busy_held", 64'(busyDropped), 64'd0);
      checkOutput("busy_clear", 64'(busy), 64'd0);
      checkOutput($sformatf("hilo op%0d %h %h", opIn, aIn, bIn), {hi, lo}, expected);
   endtask

   initial begin
      logic [63:0] expected;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          doneSeen;

      repeat (2) @(negedge clk);
      checkOutput("reset_hi", 64'(hi), 64'd0);
      checkOutput("reset_lo", 64'(lo), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      hi_we = 1'b1;
      wdata = 32'h0000_CAFE;
      @(negedge clk);
      hi_we = 1'b0;
      checkOutput("mthi", {hi, lo}, {32'h0000_CAFE, 32'd0});
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'h5555_AAAA;
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
      checkOutput("mthi_mtlo", {hi, lo}, {32'h5555_AAAA, 32'h5555_AAAA});

      applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
      applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      applyStimulus(OP_DIVU, 32'd100, 32'd0, 1'b0, 1'b0);
      applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      applyStimulus(OP_DIV, 32'hFFFF_FF9C, 32'd0, 1'b0, 1'b0);
      applyStimulus(OP_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b0, 1'b1);

      applyStimulus(OP_MULTU, 32'd12345, 32'd678, 1'b1, 1'b0);
      expected = refModel(OP_MULTU, 32'd12345, 32'd678);
      lo_we = 1'b1;
      wdata = 32'h0000_ABCD;
      @(negedge clk);
      lo_we = 1'b0;
      checkOutput("done_one_cycle", 64'(done), 64'd0);
      checkOutput("mtlo_after_run", {hi, lo}, {expected[63:32], 32'h0000_ABCD});

      for (int i = 0; i < 30; i++) begin
         rop = 2'($urandom);
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
         applyStimulus(rop, ra, rb, 1'($urandom), 1'($urandom));
      end

      start = 1'b1;
      op = OP_DIVU;
      a = 32'd1000;
      b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_hilo", {hi, lo}, 64'd0);
      checkOutput("abort_done", 64'(done), 64'd0);
      doneSeen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) doneSeen++;
      end
      checkOutput("abort_quiet", 64'(doneSeen), 64'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
